// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_control encodings and the exec-unit FSM state type.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 3;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 3'b011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Unsigned shift-add multiplier datapath: one multiplier bit retired per clock.
module mul_shift_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    output logic                 last_c,
    output logic [2*WIDTH-1:0]   product_nxt_c
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = WIDTH + 1;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] product;
    logic [CW-1:0]      count;
    logic [SW-1:0]      upper_sum;

    // Multiplier sits in the low half of product and shifts out as partial sums shift in.
    always_comb begin
        upper_sum     = {1'b0, product[2*WIDTH-1:WIDTH]}
                      + (product[0] ? {1'b0, mcand} : SW'(0));
        product_nxt_c = {upper_sum, product[WIDTH-1:1]};
    end

    assign last_c = (count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            product <= '0;
            count   <= '0;
        end else if (load) begin
            mcand   <= src_a;
            product <= {WIDTH'(0), src_b};
            count   <= CW'(WIDTH);
        end else if (count != CW'(0)) begin
            product <= product_nxt_c;
            count   <= count - CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith/slt, optional multi-cycle multiply.
// Multiply is built only when ALU_EXEC_MUL_EN is defined; otherwise op 011 is illegal.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]      src_a,
    input  logic [WIDTH-1:0]      src_b,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic [WIDTH-1:0]      hi,
    output logic                  zero,
    output logic                  illegal
);

    logic [WIDTH-1:0] op_res_c;
    logic             op_ill_c;

    // Single-cycle result; anything not decoded here is illegal and yields zero.
    always_comb begin
        op_res_c = '0;
        op_ill_c = 1'b0;
        case (alu_control)
            ALU_AND: op_res_c = src_a & src_b;
            ALU_OR:  op_res_c = src_a | src_b;
            ALU_ADD: op_res_c = src_a + src_b;
            ALU_SUB: op_res_c = src_a - src_b;
            ALU_SLT: op_res_c = WIDTH'($signed(src_a) < $signed(src_b));
            default: op_ill_c = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_MUL_EN

    alu_state_e         state;
    logic               mul_load;
    logic               mul_last_c;
    logic [2*WIDTH-1:0] product_nxt_c;

    assign mul_load = start && (state == IDLE) && (alu_control == ALU_MUL);

    mul_shift_add #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (mul_load),
        .src_a         (src_a),
        .src_b         (src_b),
        .last_c        (mul_last_c),
        .product_nxt_c (product_nxt_c)
    );

    // Requests arriving in MUL are dropped; the final step's product is captured directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            result  <= '0;
            hi      <= '0;
            zero    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (mul_load) begin
                    state <= MUL;
                    busy  <= 1'b1;
                end else if (start) begin
                    result  <= op_res_c;
                    zero    <= (op_res_c == '0);
                    illegal <= op_ill_c;
                    done    <= 1'b1;
                end
            end else if (mul_last_c) begin
                state   <= IDLE;
                busy    <= 1'b0;
                result  <= product_nxt_c[WIDTH-1:0];
                hi      <= product_nxt_c[2*WIDTH-1:WIDTH];
                zero    <= (product_nxt_c[WIDTH-1:0] == '0);
                illegal <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

`else

    assign busy = 1'b0;
    assign hi   = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            illegal <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (start) begin
                result  <= op_res_c;
                zero    <= (op_res_c == '0);
                illegal <= op_ill_c;
                done    <= 1'b1;
            end
        end
    end

`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a scoreboard of expected completions.
module tb_alu_exec_unit;

`ifdef ALU_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] hi;
        logic        zero;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        illegal;

    exp_t        exp_q[$];
    string       tag_q[$];
    exp_t        mon_e;
    string       mon_t;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    bit          busy_seen = 1'b0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .hi          (hi),
        .zero        (zero),
        .illegal     (illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},    64'(busy),    64'(0));
        chk({tag, "_done"},    64'(done),    64'(0));
        chk({tag, "_illegal"}, 64'(illegal), 64'(0));
        chk({tag, "_result"},  64'(result),  64'(0));
        chk({tag, "_hi"},      64'(hi),      64'(0));
        chk({tag, "_zero"},    64'(zero),    64'(1));
    endtask

    // Drive one request for a cycle, recording the completion it should produce.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        exp_t        e;
        logic [63:0] p;
        e.result  = 32'd0;
        e.hi      = m_hi;
        e.illegal = 1'b0;
        case (op)
            3'b000: e.result = a & b;
            3'b001: e.result = a | b;
            3'b010: e.result = a + b;
            3'b110: e.result = a - b;
            3'b111: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011: begin
                if (MUL_EN) begin
                    p        = {32'd0, a} * {32'd0, b};
                    e.result = p[31:0];
                    e.hi     = p[63:32];
                    m_hi     = p[63:32];
                end else begin
                    e.illegal = 1'b1;
                end
            end
            default: e.illegal = 1'b1;
        endcase
        e.zero      = (e.result == 32'd0);
        start       = 1'b1;
        alu_control = op;
        src_a       = a;
        src_b       = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!(MUL_EN && op == 3'b011)) begin
            chk({tag, "_done"}, 64'(done), 64'(1));
            chk({tag, "_busy"}, 64'(busy), 64'(0));
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 40 && !done) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(32));
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (rst_n && done) begin
            chk("done_has_expect", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                chk({mon_t, "_result"},  64'(result),  64'(mon_e.result));
                chk({mon_t, "_hi"},      64'(hi),      64'(mon_e.hi));
                chk({mon_t, "_zero"},    64'(zero),    64'(mon_e.zero));
                chk({mon_t, "_illegal"}, 64'(illegal), 64'(mon_e.illegal));
            end
        end
    end

    initial begin
        int  n;
        bit  busy_ok;
        bit  seen;
        rst_n       = 1'b1;
        start       = 1'b0;
        alu_control = 3'b000;
        src_a       = 32'd0;
        src_b       = 32'd0;
        #1 rst_n = 1'b0;
        #2 chk_reset("reset");
        #9 rst_n = 1'b1;

        issue(3'b010, 32'd5,         32'd7,         "add_5_7");
        issue(3'b110, 32'h3,         32'h3,         "sub_eq");
        issue(3'b111, 32'hFFFFFFFB,  32'h2,         "slt_neg");
        issue(3'b111, 32'h2,         32'hFFFFFFFB,  "slt_pos");
        issue(3'b000, 32'hF0F0F0F0,  32'hFF00FF00,  "and");
        issue(3'b001, 32'hF0F0F0F0,  32'h0F0000FF,  "or");
        issue(3'b010, 32'hFFFFFFFF,  32'h1,         "add_wrap");
        issue(3'b110, 32'h0,         32'h1,         "sub_wrap");
        @(posedge clk);
        #1;
        chk("done_single_pulse", 64'(done), 64'(0));

`ifdef ALU_EXEC_MUL_EN
        issue(3'b011, 32'hFFFFFFFF, 32'h2, "mul_ff_2");
        chk("mul_busy_start", 64'(busy), 64'(1));
        busy_ok = 1'b1;
        n = 0;
        while (n < 40 && !done) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) begin
                start       = 1'b1;
                alu_control = 3'b010;
                src_a       = 32'd1;
                src_b       = 32'd2;
            end
            if (n == 6) start = 1'b0;
            if (!done && !busy) busy_ok = 1'b0;
        end
        chk("mul_latency", 64'(n), 64'(32));
        chk("mul_busy_held", 64'(busy_ok), 64'(1));
        chk("mul_busy_end", 64'(busy), 64'(0));
        issue(3'b010, 32'd1, 32'd1, "b2b_add");

        issue(3'b011, 32'h12345678, 32'h9ABCDEF0, "mul_mix");
        wait_done("mul_mix");
        issue(3'b011, 32'h0, 32'h5, "mul_zero");
        wait_done("mul_zero");

        issue(3'b011, 32'hFFFF, 32'hFFFF, "mul_abort");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        exp_q.delete();
        tag_q.delete();
        m_hi = 32'd0;
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'(0));
        issue(3'b101, 32'h1234, 32'h5678, "op101_post_reset");
`else
        issue(3'b011, 32'd6, 32'd7, "mul_off");
`endif

        issue(3'b100, 32'hDEADBEEF, 32'h1, "op100");
        issue(3'b101, 32'h0,        32'h0, "op101");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
`ifndef ALU_EXEC_MUL_EN
        chk("busy_never_high", 64'(busy_seen), 64'(0));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  operation request, sampled on rising clk.
REQ-005 SHALL have port alu_control  input  3  op code from ALU decoder: 000 and, 001 or, 010 add, 110 sub, 111 slt, 011 mul.
REQ-006 SHALL have port src_a  input  WIDTH  operand A.
REQ-007 SHALL have port src_b  input  WIDTH  operand B.
REQ-008 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result/hi/zero/illegal valid.
REQ-010 SHALL have port result  output  WIDTH  registered result (low half for mul).
REQ-011 SHALL have port hi  output  WIDTH  upper half of mul product; unchanged by other ops.
REQ-012 SHALL have port zero  output  1  registered (result == 0).
REQ-013 SHALL have port illegal  output  1  registered; high with done for unsupported op code.

Function
REQ-014 SHALL accept start only in state IDLE; start while busy SHALL be ignored, with no effect on any output.
REQ-015 Single-cycle ops (and/or/add/sub/slt) SHALL register result, zero and illegal=0 on the accepting edge and pulse done for exactly the following cycle (latency 1).
REQ-016 add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-017 slt SHALL compare src_a < src_b as signed two's complement; result = 1 or 0, zero-extended.
REQ-018 mul SHALL be unsigned shift-add, one multiplier bit per cycle; operands captured on the accepting edge; FSM IDLE->MUL with counter loaded to WIDTH.
REQ-019 In MUL, each edge SHALL decrement the counter; on the edge where the counter reaches 0, FSM SHALL return to IDLE, drive result=product[WIDTH-1:0], hi=product[2*WIDTH-1:WIDTH], zero=(result==0), and pulse done (done visible WIDTH cycles after the accepting edge).
REQ-020 busy SHALL be high from the accepting edge of a mul until the edge that raises done.
REQ-021 start asserted in the same cycle that done is high SHALL be accepted (back-to-back issue, no bubble).
REQ-022 Op codes 100, 101 (and 011 when mul is compiled out) SHALL complete in 1 cycle with result=0, zero=1, illegal=1, hi unchanged.
REQ-023 done SHALL never stay high longer than one cycle without a new accepted start.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, counter 0, busy=0, done=0, illegal=0, result=0, hi=0, zero=1.
REQ-025 Reset during MUL SHALL abort the operation; no done pulse SHALL follow after reset release.
REQ-026 First start SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-027 With macro ALU_EXEC_MUL_EN defined, mul SHALL be implemented per REQ-018..REQ-020.
REQ-028 Without ALU_EXEC_MUL_EN, no MUL state or multiplier logic SHALL exist, busy SHALL be tied 0, hi SHALL stay 0, and 011 SHALL be treated as illegal per REQ-022.

Structure
REQ-029 Package alu_pkg SHALL hold the alu_control encodings as named constants and the FSM state type (IDLE, MUL).
REQ-030 Shift-add datapath (product/multiplicand registers, counter) SHALL be sub-module mul_shift_add, instantiated only under ALU_EXEC_MUL_EN.

Verification (WIDTH=32)
REQ-031 add 5+7 -> next cycle done=1, result=12, zero=0, illegal=0.
REQ-032 sub 0x3-0x3 -> result=0, zero=1; slt 0xFFFFFFFB vs 0x2 -> result=1.
REQ-033 mul 0xFFFFFFFF*0x2 -> busy high 32 cycles, done at cycle 32, result=0xFFFFFFFE, hi=0x1; start(add) during busy ignored.
REQ-034 mul completes, add 1+1 issued in the done cycle -> accepted, done next cycle with result=2.
REQ-035 rst_n low at mul cycle 10 -> all outputs at reset values immediately, no done afterwards; op 101 -> illegal=1, result=0.
REQ-036 Build without ALU_EXEC_MUL_EN: op 011 -> 1-cycle done, illegal=1, busy never high.
